// File: rtl/lib_mux_fifo_n_if.sv
// lib_mux_fifo_n_if: valid/ready bundle for the multi-channel ingress buffer.
// Carries the per-channel input handshakes and the merged output handshake.
// The slave modport is the buffer itself. The master modport is the producers
// and consumer around it.
interface lib_mux_fifo_n_if #(
   parameter int NUM_CH   = 4,
   parameter int NUM_BITS = 32
);
   localparam int CH_W = $clog2(NUM_CH);

   logic [NUM_CH-1:0]               in_val;
   logic [NUM_CH-1:0][NUM_BITS-1:0] in_d;
   logic [NUM_CH-1:0]               in_rdy;
   logic                            out_val;
   logic [NUM_BITS-1:0]             out_d;
   logic [CH_W-1:0]                 out_ch;
   logic                            out_rdy;

   modport slave (
      input  in_val, in_d, out_rdy,
      output in_rdy, out_val, out_d, out_ch
   );

   modport master (
      output in_val, in_d, out_rdy,
      input  in_rdy, out_val, out_d, out_ch
   );
endinterface

// File: rtl/lib_mux_fifo_n.sv
// lib_mux_fifo_n: NUM_CH independent DEPTH-entry FIFOs merged onto one
// valid/ready output by a round-robin arbiter. The arbiter locks its grant
// while the output is stalled. Each channel reports its occupancy and an
// almost-full flag, and can be flushed.
// Optional feature macro: LIB_MUX_FIFO_CUT_THRU_EN. When it is defined and
// every FIFO is empty with the lock clear, the round-robin-selected input
// drives the output combinationally. If the consumer takes the beat in that
// same cycle, the beat skips the FIFO entirely.
module lib_mux_fifo_n #(
   parameter int NUM_CH    = 4,
   parameter int DEPTH     = 4,
   parameter int NUM_BITS  = 32,
   parameter int AFULL_LVL = DEPTH - 1
) (
   input  logic                                      clk,
   input  logic                                      rstn,
   lib_mux_fifo_n_if.slave                           bus,
   input  logic [NUM_CH-1:0]                         flush,
   output logic [NUM_CH-1:0][$clog2(DEPTH+1)-1:0]    count,
   output logic [NUM_CH-1:0]                         afull
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CH_W  = $clog2(NUM_CH);
   localparam int CNT_W = $clog2(DEPTH+1);

   typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

   logic [NUM_BITS-1:0]          mem [NUM_CH][DEPTH];
   logic [NUM_CH-1:0][PTR_W-1:0] wr_ptr;
   logic [NUM_CH-1:0][PTR_W-1:0] rd_ptr;
   logic [NUM_CH-1:0]            wr_wrap;
   logic [NUM_CH-1:0]            rd_wrap;

   logic [NUM_CH-1:0]            empty;
   logic [NUM_CH-1:0]            full;
   logic [NUM_CH-1:0]            eligible;
   logic [NUM_CH-1:0]            in_rdy_c;
   logic [NUM_CH-1:0]            push;
   logic [NUM_CH-1:0]            pop;

   arb_state_t                   state;
   arb_state_t                   state_nxt;
   logic [CH_W-1:0]              rr_ptr;
   logic [CH_W-1:0]              lock_ch;
   logic [CH_W-1:0]              rr_sel;
   logic                         rr_found;
   logic [CH_W-1:0]              out_ch_c;
   logic                         out_val_c;
   logic [NUM_BITS-1:0]          out_d_c;
   logic                         accept;
   logic                         bypass;

`ifdef LIB_MUX_FIFO_CUT_THRU_EN
   logic [CH_W-1:0]              cut_sel;
   logic                         cut_found;
   logic                         any_data;
`endif

   // Per-channel status derived from the registered pointers: empty/full from the wrap bits, occupancy, almost-full and ready
   always_comb begin
      int cnt;
      cnt      = 0;
      empty    = '0;
      full     = '0;
      eligible = '0;
      in_rdy_c = '0;
      count    = '0;
      afull    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         empty[i] = (wr_ptr[i] == rd_ptr[i]) && (wr_wrap[i] == rd_wrap[i]);
         full[i]  = (wr_ptr[i] == rd_ptr[i]) && (wr_wrap[i] != rd_wrap[i]);
         if (wr_wrap[i] == rd_wrap[i])
            cnt = int'(wr_ptr[i]) - int'(rd_ptr[i]);
         else
            cnt = DEPTH + int'(wr_ptr[i]) - int'(rd_ptr[i]);
         count[i]    = CNT_W'(cnt);
         afull[i]    = (cnt >= AFULL_LVL);
         in_rdy_c[i] = !full[i] && !flush[i];
         eligible[i] = !empty[i] && !flush[i];
      end
   end

   assign bus.in_rdy = in_rdy_c;

   // Round-robin search: the first eligible channel after the last granted one, wrapping around
   always_comb begin
      int idx;
      idx      = 0;
      rr_sel   = '0;
      rr_found = 1'b0;
`ifdef LIB_MUX_FIFO_CUT_THRU_EN
      cut_sel   = '0;
      cut_found = 1'b0;
      any_data  = |(~empty);
`endif
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = (int'(rr_ptr) + k) % NUM_CH;
         if (!rr_found && eligible[idx]) begin
            rr_found = 1'b1;
            rr_sel   = CH_W'(idx);
         end
`ifdef LIB_MUX_FIFO_CUT_THRU_EN
         if (!cut_found && bus.in_val[idx] && !flush[idx]) begin
            cut_found = 1'b1;
            cut_sel   = CH_W'(idx);
         end
`endif
      end
   end

   // Arbiter state register: lock state, locked channel and round-robin pointer
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state   <= ST_IDLE;
         lock_ch <= '0;
         rr_ptr  <= CH_W'(NUM_CH - 1);
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE)
            lock_ch <= out_ch_c;
         if (accept)
            rr_ptr <= out_ch_c;
      end
   end

   // Arbiter next state: lock on a stalled beat; release on accept or when the locked channel is flushed
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (out_val_c && !bus.out_rdy) state_nxt = ST_LOCKED;
         ST_LOCKED: if (accept || flush[lock_ch] || !out_val_c) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Arbiter outputs: a held grant while locked, otherwise the round-robin pick (or a cut-through input beat)
   always_comb begin
      bypass    = 1'b0;
      out_ch_c  = rr_sel;
      out_val_c = rr_found;
      if (state == ST_LOCKED) begin
         out_ch_c  = lock_ch;
         out_val_c = eligible[lock_ch];
      end
      out_d_c = mem[out_ch_c][rd_ptr[out_ch_c]];
`ifdef LIB_MUX_FIFO_CUT_THRU_EN
      if (state == ST_IDLE && !any_data && cut_found) begin
         out_ch_c  = cut_sel;
         out_val_c = 1'b1;
         out_d_c   = bus.in_d[cut_sel];
         bypass    = bus.out_rdy;
      end
`endif
   end

   assign bus.out_val = out_val_c;
   assign bus.out_ch  = out_ch_c;
   assign bus.out_d   = out_d_c;
   assign accept      = out_val_c && bus.out_rdy;

   // Push/pop strobes; a bypassed beat neither writes nor pops its FIFO
   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         push[i] = bus.in_val[i] && in_rdy_c[i] && !(bypass && (out_ch_c == CH_W'(i)));
         pop[i]  = accept && !bypass && (out_ch_c == CH_W'(i));
      end
   end

   // Pointer update with modulo-DEPTH wrap; flush clears the channel outright
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         wr_wrap <= '0;
         rd_wrap <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (flush[i]) begin
               wr_ptr[i]  <= '0;
               rd_ptr[i]  <= '0;
               wr_wrap[i] <= 1'b0;
               rd_wrap[i] <= 1'b0;
            end else begin
               if (push[i]) begin
                  if (wr_ptr[i] == PTR_W'(DEPTH - 1)) begin
                     wr_ptr[i]  <= '0;
                     wr_wrap[i] <= !wr_wrap[i];
                  end else begin
                     wr_ptr[i] <= wr_ptr[i] + 1'b1;
                  end
               end
               if (pop[i]) begin
                  if (rd_ptr[i] == PTR_W'(DEPTH - 1)) begin
                     rd_ptr[i]  <= '0;
                     rd_wrap[i] <= !rd_wrap[i];
                  end else begin
                     rd_ptr[i] <= rd_ptr[i] + 1'b1;
                  end
               end
            end
         end
      end
   end

   // FIFO storage write; the contents need no reset because the pointers gate every read
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i])
            mem[i][wr_ptr[i]] <= bus.in_d[i];
      end
   end
endmodule

// File: tb/tb_lib_mux_fifo_n.sv
// tb_lib_mux_fifo_n: directed testbench for lib_mux_fifo_n (NUM_CH=4, DEPTH=4).
// Expected behaviour follows LIB_MUX_FIFO_CUT_THRU_EN when it is defined.
module tb_lib_mux_fifo_n;
   logic             clk;
   logic             rstn;
   logic [3:0]       flush;
   logic [3:0][2:0]  count;
   logic [3:0]       afull;
   int               checks;
   int               failures;

   lib_mux_fifo_n_if #(.NUM_CH(4), .NUM_BITS(32)) bus ();

   lib_mux_fifo_n #(.NUM_CH(4), .DEPTH(4), .NUM_BITS(32), .AFULL_LVL(3)) dut (
      .clk   (clk),
      .rstn  (rstn),
      .bus   (bus),
      .flush (flush),
      .count (count),
      .afull (afull)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rstn        = 1'b0;
      bus.in_val  = '0;
      bus.in_d    = '0;
      bus.out_rdy = 1'b0;
      flush       = '0;
      tick();
      tick();
      rstn = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_val got=%0b want=0", bus.out_val); end
      checks++; if (bus.out_ch !== 2'd0) begin failures++; $display("[TB] FAIL reset_out_ch got=%0d want=0", bus.out_ch); end
      checks++; if (count !== 12'd0) begin failures++; $display("[TB] FAIL reset_count got=%h want=0", count); end
      checks++; if (afull !== 4'd0) begin failures++; $display("[TB] FAIL reset_afull got=%b want=0000", afull); end
      checks++; if (bus.in_rdy !== 4'hF) begin failures++; $display("[TB] FAIL reset_in_rdy got=%b want=1111", bus.in_rdy); end
      tick();
      rstn = 1'b1;
      #1;
      // Load ch1 with three words, then pull reset mid-cycle
      bus.out_rdy = 1'b0;
      bus.in_val  = 4'b0010;
      for (int k = 0; k < 3; k++) begin
         bus.in_d[1] = 32'h11 + k;
         tick();
      end
      bus.in_val = '0;
      #1;
      checks++; if (count[1] !== 3'd3) begin failures++; $display("[TB] FAIL mid_count1 got=%0d want=3", count[1]); end
      #1;
      rstn = 1'b0;
      #1;
      checks++; if (bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL async_out_val got=%0b want=0", bus.out_val); end
      checks++; if (count !== 12'd0) begin failures++; $display("[TB] FAIL async_count got=%h want=0", count); end
      tick();
      rstn = 1'b1;
      bus.in_val  = 4'b0100;
      bus.in_d[2] = 32'h77;
      tick();
      bus.in_val = '0;
      #1;
      checks++; if (bus.out_val !== 1'b1) begin failures++; $display("[TB] FAIL post_rst_val got=%0b want=1", bus.out_val); end
      checks++; if (bus.out_ch !== 2'd2) begin failures++; $display("[TB] FAIL post_rst_ch got=%0d want=2", bus.out_ch); end
      checks++; if (bus.out_d !== 32'h77) begin failures++; $display("[TB] FAIL post_rst_d got=%h want=77", bus.out_d); end
   endtask

   task automatic test_fill_drain();
      reset_dut();
      bus.out_rdy = 1'b0;
      bus.in_val  = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         bus.in_d[0] = 32'hA0 + k;
         tick();
         checks++; if (count[0] !== 3'(k + 1)) begin failures++; $display("[TB] FAIL fill_count%0d got=%0d want=%0d", k, count[0], k + 1); end
         checks++; if (afull[0] !== (k >= 2)) begin failures++; $display("[TB] FAIL fill_afull%0d got=%0b want=%0b", k, afull[0], (k >= 2)); end
      end
      bus.in_val = '0;
      #1;
      checks++; if (bus.in_rdy[0] !== 1'b0) begin failures++; $display("[TB] FAIL full_in_rdy got=%0b want=0", bus.in_rdy[0]); end
      bus.out_rdy = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (bus.out_val !== 1'b1 || bus.out_d !== 32'hA0 + k) begin failures++; $display("[TB] FAIL drain%0d got val=%0b d=%h want val=1 d=%h", k, bus.out_val, bus.out_d, 32'hA0 + k); end
         tick();
      end
      checks++; if (bus.out_val !== 1'b0 || count[0] !== 3'd0) begin failures++; $display("[TB] FAIL drained got val=%0b cnt=%0d want 0/0", bus.out_val, count[0]); end
      bus.out_rdy = 1'b0;
   endtask

   task automatic test_round_robin();
      int exp_ch;
      reset_dut();
      bus.out_rdy = 1'b0;
      bus.in_val  = 4'hF;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 4; i++) bus.in_d[i] = 32'h100 * i + k;
         tick();
      end
      bus.in_val = '0;
      tick();
      bus.out_rdy = 1'b1;
      #1;
      for (int n = 0; n < 8; n++) begin
         exp_ch = n % 4;
         checks++; if (bus.out_ch !== 2'(exp_ch) || bus.out_d !== 32'(32'h100 * exp_ch + n / 4)) begin
            failures++; $display("[TB] FAIL rr%0d got ch=%0d d=%h want ch=%0d d=%h", n, bus.out_ch, bus.out_d, exp_ch, 32'h100 * exp_ch + n / 4);
         end
         tick();
      end
      checks++; if (bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL rr_empty got=%0b want=0", bus.out_val); end
      bus.out_rdy = 1'b0;
   endtask

   task automatic test_lock_hold();
      reset_dut();
      bus.out_rdy = 1'b0;
      bus.in_val  = 4'b0100;
      bus.in_d[2] = 32'h22;
      tick();
      bus.in_val  = 4'b0001;
      bus.in_d[0] = 32'h0C;
      for (int c = 0; c < 3; c++) begin
         checks++; if (bus.out_val !== 1'b1 || bus.out_ch !== 2'd2 || bus.out_d !== 32'h22) begin
            failures++; $display("[TB] FAIL lock%0d got val=%0b ch=%0d d=%h want 1/2/22", c, bus.out_val, bus.out_ch, bus.out_d);
         end
         tick();
         bus.in_val = '0;
      end
      bus.out_rdy = 1'b1;
      #1;
      checks++; if (bus.out_ch !== 2'd2) begin failures++; $display("[TB] FAIL lock_accept_ch got=%0d want=2", bus.out_ch); end
      tick();
      checks++; if (bus.out_ch !== 2'd0 || bus.out_d !== 32'h0C) begin failures++; $display("[TB] FAIL lock_next got ch=%0d d=%h want 0/0c", bus.out_ch, bus.out_d); end
      bus.out_rdy = 1'b0;
   endtask

   task automatic test_flush();
      reset_dut();
      bus.out_rdy = 1'b0;
      bus.in_val  = 4'b0100;
      bus.in_d[2] = 32'h2A;
      tick();
      bus.in_d[2] = 32'h2B;
      tick();
      bus.in_val = '0;
      #1;
      checks++; if (count[2] !== 3'd2 || bus.out_ch !== 2'd2 || bus.out_val !== 1'b1) begin
         failures++; $display("[TB] FAIL flush_pre got cnt=%0d ch=%0d val=%0b want 2/2/1", count[2], bus.out_ch, bus.out_val);
      end
      flush       = 4'b0100;
      bus.in_val  = 4'b0100;
      bus.in_d[2] = 32'h2C;
      #1;
      checks++; if (bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL flush_val got=%0b want=0", bus.out_val); end
      checks++; if (bus.in_rdy[2] !== 1'b0) begin failures++; $display("[TB] FAIL flush_rdy got=%0b want=0", bus.in_rdy[2]); end
      tick();
      flush      = '0;
      bus.in_val = '0;
      #1;
      checks++; if (count[2] !== 3'd0 || bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL flush_post got cnt=%0d val=%0b want 0/0", count[2], bus.out_val); end
      checks++; if (bus.in_rdy[2] !== 1'b1) begin failures++; $display("[TB] FAIL flush_rdy_back got=%0b want=1", bus.in_rdy[2]); end
   endtask

   task automatic test_latency();
      reset_dut();
      bus.out_rdy = 1'b1;
      bus.in_val  = 4'b1000;
      bus.in_d[3] = 32'h55;
      #1;
`ifdef LIB_MUX_FIFO_CUT_THRU_EN
      checks++; if (bus.out_val !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_d !== 32'h55) begin
         failures++; $display("[TB] FAIL cut_same got val=%0b ch=%0d d=%h want 1/3/55", bus.out_val, bus.out_ch, bus.out_d);
      end
      tick();
      bus.in_val = '0;
      #1;
      checks++; if (count[3] !== 3'd0 || bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL cut_after got cnt=%0d val=%0b want 0/0", count[3], bus.out_val); end
`else
      checks++; if (bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL lat_same got=%0b want=0", bus.out_val); end
      tick();
      bus.in_val = '0;
      #1;
      checks++; if (bus.out_val !== 1'b1 || bus.out_ch !== 2'd3 || bus.out_d !== 32'h55 || count[3] !== 3'd1) begin
         failures++; $display("[TB] FAIL lat_next got val=%0b ch=%0d d=%h cnt=%0d want 1/3/55/1", bus.out_val, bus.out_ch, bus.out_d, count[3]);
      end
      tick();
      checks++; if (count[3] !== 3'd0 || bus.out_val !== 1'b0) begin failures++; $display("[TB] FAIL lat_drain got cnt=%0d val=%0b want 0/0", count[3], bus.out_val); end
`endif
      bus.out_rdy = 1'b0;
   endtask

   // Run every scenario in order, then report
   initial begin
      checks      = 0;
      failures    = 0;
      rstn        = 1'b0;
      flush       = '0;
      bus.in_val  = '0;
      bus.in_d    = '0;
      bus.out_rdy = 1'b0;
      test_reset();
      test_fill_drain();
      test_round_robin();
      test_lock_hold();
      test_flush();
      test_latency();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lib_mux_fifo_n.md
# lib_mux_fifo_n

Multi-channel ingress buffer: `NUM_CH` independent valid/ready input channels, each with a private `DEPTH`-entry FIFO, merged onto one valid/ready output by a round-robin arbiter that locks its grant while the output is stalled. It supersedes single-channel n-entry pipes at points where several producers share one consumer, such as the request merge in front of the LSU/fabric port. It adds per-channel occupancy, almost-full and flush.

## Interface
Parameters:
- `NUM_CH`, 4, number of input channels (≥2)
- `DEPTH`, 4, entries per channel FIFO (≥2, any integer, not only powers of 2)
- `NUM_BITS`, 32, payload width
- `AFULL_LVL`, `DEPTH-1`, occupancy at or above which `afull[i]` asserts (1..`DEPTH`)

Ports:
- `clk` in 1: the single clock
- `rstn` in 1: reset, asynchronous, active-low
- `in_val` in `[NUM_CH-1:0]`: per-channel valid
- `in_d` in `[NUM_CH-1:0][NUM_BITS-1:0]`: per-channel payload
- `in_rdy` out `[NUM_CH-1:0]`: per-channel ready
- `flush` in `[NUM_CH-1:0]`: discard the channel's contents
- `out_val` out 1: output valid
- `out_d` out `NUM_BITS`: output payload
- `out_ch` out `$clog2(NUM_CH)`: source channel of `out_d`
- `out_rdy` in 1: consumer ready
- `count` out `[NUM_CH-1:0][$clog2(DEPTH+1)-1:0]`: per-channel occupancy
- `afull` out `[NUM_CH-1:0]`: `count[i] >= AFULL_LVL`

## Operation
- Reset (async assert, sync release) values:
  - all FIFO pointers and wrap bits are 0.
  - `count` = 0, `afull` = 0, `in_rdy` = all 1, `out_val` = 0, `out_ch` = 0.
  - Lock is clear.
  - RR pointer = `NUM_CH-1`, so channel 0 has the highest priority first.
- Push: channel i writes when `in_val[i] && in_rdy[i]`. `in_rdy[i] = !full[i] && !flush[i]`, so `in_rdy` has no combinational path from `out_rdy`. A full FIFO does not accept a push in the same cycle it pops.
- Pointers: modulo-`DEPTH` read/write pointers, each with a wrap bit.
  - empty = pointers and wrap bits equal.
  - full = pointers equal, wrap bits differ.
  - `count` = write position minus read position, in the range 0..`DEPTH`.
- Eligible channel: non-empty and `flush` low.
- Arbitration states:
  - **IDLE** (lock clear): grant goes to the first eligible channel searching from RR pointer+1 upward, with wrap. `out_val` = any channel eligible.
  - **LOCKED**: entered when `out_val && !out_rdy`. Grant, `out_ch` and `out_d` are held until accept, even if a higher-priority channel becomes eligible. Exit on accept, or on `flush[out_ch]`.
- Accept (`out_val && out_rdy`):
  - pop the granted FIFO
  - RR pointer ← `out_ch`
  - lock cleared
- Flush of channel i:
  - At the clock edge: pointers ← 0, wrap bits ← 0, `count[i]` ← 0. Any push in that cycle is dropped.
  - Same cycle: if channel i is locked, `out_val` may fall. This is the only permitted valid-withdrawal.
- Simultaneous push and pop on one channel: `count` is unchanged and data order is preserved.

## Timing
- Push to `out_val`, empty channel, no contention: 1 cycle (write at edge N, `out_val` high after edge N).
- Sustained throughput: 1 beat/cycle on the output. A single channel sustains 1 beat/cycle when `DEPTH` ≥ 2.
- Fairness: with all channels continuously eligible, grants rotate 0,1,…,`NUM_CH-1`, 0.
- `count` and `afull` are registered/derived from registered pointers and update the cycle after the push or pop edge.

## Configuration
- `LIB_MUX_FIFO_CUT_THRU_EN` defined: when no FIFO holds data and the lock is clear, the RR-selected `in_val` channel drives `out_val`/`out_d`/`out_ch` combinationally.
  - If `out_rdy`=1 that cycle, the beat bypasses the FIFO: no write, `count` stays 0, pointer updates as a normal accept.
  - If `out_rdy`=0, the beat is written normally and the lock engages the next cycle.
  - Latency is 0 cycles.
- Undefined: no input→output combinational path; minimum latency is 1 cycle.

## Test plan
- Reset mid-traffic (ch1 holding 3 entries, `rstn`=0 asynchronously) -> `out_val`=0, `count`=0 immediately; after release, the first push on ch2 appears with `out_ch`=2 one cycle later.
- Fill ch0 with `DEPTH`=4 words 0xA0..0xA3 with `out_rdy`=0 -> `in_rdy[0]`=0, `count[0]`=4, `afull[0]`=1 from the 3rd entry; then `out_rdy`=1 -> 0xA0..0xA3 drained in order over 4 cycles.
- All 4 channels loaded with 2 words each, `out_rdy`=1 -> `out_ch` sequence 0,1,2,3,0,1,2,3.
- ch2 presented with `out_rdy`=0 for 3 cycles while ch0 becomes non-empty -> `out_ch` stays 2 and `out_d` is stable until accept; ch0 is granted next.
- `flush[2]` while ch2 is locked holding 2 entries -> `out_val` drops that cycle, `count[2]`=0 next cycle, and the concurrent push on ch2 is dropped.
- With `LIB_MUX_FIFO_CUT_THRU_EN`, all FIFOs empty, ch3 pushes 0x55 with `out_rdy`=1 -> `out_d`=0x55, `out_ch`=3 in the same cycle and `count[3]` stays 0. Without the macro, the same beat appears one cycle later.
